// File: rtl/branch_predict_ctrl.sv
// Branch predictor: direct-mapped BHT/BTB with 2-bit counters, resolved in MEM.
// Define BPU_STATS_EN to add resolved-branch and misprediction counters.
module branch_predict_ctrl #(
    parameter int BHT_IDX_W = 4,
    parameter int TAG_W     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_pc,
    input  logic        i_mem_is_br,
    input  logic        i_mem_is_jmp,
    input  logic        i_mem_taken,
    input  logic [31:0] i_mem_target,
    input  logic        i_mem_pred_taken,
    input  logic [31:0] i_mem_pred_target,
    input  logic        i_stall,
`ifdef BPU_STATS_EN
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt,
`endif
    output logic        o_flush,
    output logic [31:0] o_redirect_pc
);

    localparam int N = 1 << BHT_IDX_W;

    logic [1:0]       ctr_q    [N];
    logic             valid_q  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [31:0]      target_q [N];

    logic [BHT_IDX_W-1:0] if_idx;
    logic [TAG_W-1:0]     if_tag;
    logic                 if_hit;

    logic [BHT_IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 upd_hit;
    logic                 resolve;
    logic                 mispredict;

    logic                 upd_we;
    logic [1:0]           ent_ctr_d;
    logic                 ent_valid_d;
    logic [TAG_W-1:0]     ent_tag_d;
    logic [31:0]          ent_target_d;

    assign if_idx = i_if_pc[2 +: BHT_IDX_W];
    assign if_tag = i_if_pc[2 + BHT_IDX_W +: TAG_W];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
    assign o_pred_taken  = if_hit && ctr_q[if_idx][1];
    assign o_pred_target = o_pred_taken ? target_q[if_idx] : i_if_pc + 32'd4;

    assign upd_idx = i_mem_pc[2 +: BHT_IDX_W];
    assign upd_tag = i_mem_pc[2 + BHT_IDX_W +: TAG_W];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign resolve    = i_mem_valid && (i_mem_is_br || i_mem_is_jmp) && !i_stall;
    assign mispredict = (i_mem_taken != i_mem_pred_taken) ||
                        (i_mem_taken && (i_mem_target != i_mem_pred_target));

    assign o_flush       = resolve && mispredict;
    assign o_redirect_pc = i_mem_taken ? i_mem_target : i_mem_pc + 32'd4;

    always_comb begin
        upd_we       = 1'b0;
        ent_ctr_d    = ctr_q[upd_idx];
        ent_valid_d  = valid_q[upd_idx];
        ent_tag_d    = tag_q[upd_idx];
        ent_target_d = target_q[upd_idx];
        if (resolve) begin
            if (i_mem_is_jmp) begin
                upd_we       = 1'b1;
                ent_ctr_d    = 2'b11;
                ent_valid_d  = 1'b1;
                ent_tag_d    = upd_tag;
                ent_target_d = i_mem_target;
            end else if (upd_hit) begin
                upd_we = 1'b1;
                if (i_mem_taken) begin
                    ent_ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    ent_valid_d  = 1'b1;
                    ent_tag_d    = upd_tag;
                    ent_target_d = i_mem_target;
                end else begin
                    ent_ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (i_mem_taken) begin
                // A taken branch that misses evicts the occupant, starting weakly taken.
                upd_we       = 1'b1;
                ent_ctr_d    = 2'b10;
                ent_valid_d  = 1'b1;
                ent_tag_d    = upd_tag;
                ent_target_d = i_mem_target;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctr_q[i]    <= 2'b01;
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (upd_we) begin
            ctr_q[upd_idx]    <= ent_ctr_d;
            valid_q[upd_idx]  <= ent_valid_d;
            tag_q[upd_idx]    <= ent_tag_d;
            target_q[upd_idx] <= ent_target_d;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve) br_cnt_q <= br_cnt_q + 32'd1;
            if (o_flush) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign o_br_cnt      = br_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed scoreboard bench for branch_predict_ctrl; checks counters too when BPU_STATS_EN is defined.
module tb_branch_predict_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_mem_valid;
    logic [31:0] i_mem_pc;
    logic        i_mem_is_br;
    logic        i_mem_is_jmp;
    logic        i_mem_taken;
    logic [31:0] i_mem_target;
    logic        i_mem_pred_taken;
    logic [31:0] i_mem_pred_target;
    logic        i_stall;
    logic        o_flush;
    logic [31:0] o_redirect_pc;
`ifdef BPU_STATS_EN
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;
`endif

    branch_predict_ctrl #(.BHT_IDX_W(4), .TAG_W(8)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_if_pc           (i_if_pc),
        .o_pred_taken      (o_pred_taken),
        .o_pred_target     (o_pred_target),
        .i_mem_valid       (i_mem_valid),
        .i_mem_pc          (i_mem_pc),
        .i_mem_is_br       (i_mem_is_br),
        .i_mem_is_jmp      (i_mem_is_jmp),
        .i_mem_taken       (i_mem_taken),
        .i_mem_target      (i_mem_target),
        .i_mem_pred_taken  (i_mem_pred_taken),
        .i_mem_pred_target (i_mem_pred_target),
        .i_stall           (i_stall),
`ifdef BPU_STATS_EN
        .o_br_cnt          (o_br_cnt),
        .o_mispred_cnt     (o_mispred_cnt),
`endif
        .o_flush           (o_flush),
        .o_redirect_pc     (o_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    typedef enum {K_PTAKEN, K_PTARGET, K_FLUSH, K_REDIR, K_BRCNT, K_MISCNT} kind_e;
    typedef struct {
        kind_e       kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   expBr       = 0;
    int   expMis      = 0;

    function automatic logic [31:0] observe(kind_e k);
        logic [31:0] v;
        v = 'x;
        case (k)
            K_PTAKEN:  v = {31'd0, o_pred_taken};
            K_PTARGET: v = o_pred_target;
            K_FLUSH:   v = {31'd0, o_flush};
            K_REDIR:   v = o_redirect_pc;
`ifdef BPU_STATS_EN
            K_BRCNT:   v = o_br_cnt;
            K_MISCNT:  v = o_mispred_cnt;
`endif
            default:   v = 'x;
        endcase
        return v;
    endfunction

    // Drive one cycle of inputs; the bench tallies resolution cycles for the counter check.
    task automatic applyStimulus(input logic [31:0] ifPc, input logic mv, input logic [31:0] mpc,
                                 input logic br, input logic jmp, input logic tk,
                                 input logic [31:0] tgt, input logic ptk,
                                 input logic [31:0] ptgt, input logic stall);
        i_if_pc           = ifPc;
        i_mem_valid       = mv;
        i_mem_pc          = mpc;
        i_mem_is_br       = br;
        i_mem_is_jmp      = jmp;
        i_mem_taken       = tk;
        i_mem_target      = tgt;
        i_mem_pred_taken  = ptk;
        i_mem_pred_target = ptgt;
        i_stall           = stall;
        if (mv && (br || jmp) && !stall) expBr++;
    endtask

    task automatic idle(input logic [31:0] ifPc);
        applyStimulus(ifPc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic pushExp(input kind_e k, input string name, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.name = name;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic expectPred(input string name, input logic tk, input logic [31:0] tgt);
        pushExp(K_PTAKEN, {name, ".ptaken"}, {31'd0, tk});
        pushExp(K_PTARGET, {name, ".ptarget"}, tgt);
    endtask

    task automatic expectFlush(input string name, input logic f, input logic [31:0] redir);
        pushExp(K_FLUSH, {name, ".flush"}, {31'd0, f});
        if (f) begin
            pushExp(K_REDIR, {name, ".redirect"}, redir);
            expMis++;
        end
    endtask

    task automatic expectStats(input string name);
`ifdef BPU_STATS_EN
        pushExp(K_BRCNT, {name, ".br_cnt"}, 32'(expBr));
        pushExp(K_MISCNT, {name, ".mispred_cnt"}, 32'(expMis));
`else
        if (name.len() < 0) $display("[TB] %s", name);
`endif
    endtask

    // Sample on the falling edge, drain the scoreboard, then advance past the next rising edge.
    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        @(negedge i_clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            testsRun++;
            assert (obs === e.exp) else begin
                testsFailed++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", e.name, obs, e.exp);
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        idle(32'h100);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        idle(32'h100);
        expectPred("reset", 1'b0, 32'h104); expectFlush("reset", 1'b0, 0); expectStats("reset");
        checkOutput();

        // BEQ at 0x100 -> 0x80, taken twice with pred not-taken
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
        expectPred("beq1", 1'b0, 32'h104); expectFlush("beq1", 1'b1, 32'h80);
        checkOutput();
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
        expectPred("beq2", 1'b1, 32'h80); expectFlush("beq2", 1'b1, 32'h80);
        checkOutput();

        // Counter at 11: two not-taken resolutions step it down to 01
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 0);
        expectPred("nt1", 1'b1, 32'h80); expectFlush("nt1", 1'b1, 32'h104);
        checkOutput();
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 0);
        expectPred("nt2", 1'b1, 32'h80); expectFlush("nt2", 1'b1, 32'h104);
        checkOutput();
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0);
        expectPred("nt3", 1'b0, 32'h104); expectFlush("nt3", 1'b0, 0);
        checkOutput();
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0);
        expectPred("nt4", 1'b0, 32'h104); expectFlush("nt4", 1'b0, 0);
        checkOutput();

        // From saturated 00, two taken resolutions are needed to predict taken
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
        expectPred("sat1", 1'b0, 32'h104); expectFlush("sat1", 1'b1, 32'h80);
        checkOutput();
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 0);
        expectPred("sat2", 1'b0, 32'h104); expectFlush("sat2", 1'b1, 32'h80);
        checkOutput();
        idle(32'h100);
        expectPred("sat3", 1'b1, 32'h80);
        checkOutput();

        // Stalled mispredict: no flush, no table change; flush once released
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1);
        expectPred("stall1", 1'b1, 32'h80); expectFlush("stall1", 1'b0, 0);
        checkOutput();
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 0);
        expectPred("stall2", 1'b1, 32'h80); expectFlush("stall2", 1'b1, 32'h104);
        checkOutput();
        idle(32'h100);
        expectPred("stall3", 1'b0, 32'h104);
        checkOutput();

        // JALR at 0x200 (same index, other tag) to 0x300 with wrong predicted target
        applyStimulus(32'h200, 1, 32'h200, 0, 1, 1, 32'h300, 1, 32'h250, 0);
        expectPred("jalr1", 1'b0, 32'h204); expectFlush("jalr1", 1'b1, 32'h300);
        checkOutput();
        idle(32'h200);
        expectPred("jalr2", 1'b1, 32'h300);
        checkOutput();

        // Not-taken branch that misses leaves the entry alone
        applyStimulus(32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104, 0);
        expectPred("ntmiss", 1'b0, 32'h104); expectFlush("ntmiss", 1'b0, 0);
        checkOutput();
        applyStimulus(32'h200, 1, 32'h200, 0, 1, 1, 32'h300, 1, 32'h300, 0);
        expectPred("jalok", 1'b1, 32'h300); expectFlush("jalok", 1'b0, 0);
        checkOutput();

        // PC wrap at the top of the address space
        applyStimulus(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0, 0, 32'h10, 1, 32'h10, 0);
        expectPred("wrap", 1'b0, 32'h0); expectFlush("wrap", 1'b1, 32'h0);
        checkOutput();

        // Non-resolution cycles never flush
        applyStimulus(32'h200, 0, 32'h100, 1, 0, 1, 32'h999, 0, 32'h0, 0);
        expectPred("novalid", 1'b1, 32'h300); expectFlush("novalid", 1'b0, 0);
        checkOutput();
        applyStimulus(32'h200, 1, 32'h100, 0, 0, 1, 32'h999, 0, 32'h0, 0);
        expectPred("nobr", 1'b1, 32'h300); expectFlush("nobr", 1'b0, 0);
        checkOutput();
        idle(32'h200);
        expectPred("totals", 1'b1, 32'h300); expectStats("totals");
        checkOutput();

        // Reset during a pending taken update at 0x144: nothing gets written
        applyStimulus(32'h144, 1, 32'h144, 1, 0, 1, 32'h500, 0, 32'h148, 0);
        #2;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        idle(32'h144);
        i_rst_n = 1'b1;
        expBr  = 0;
        expMis = 0;
        expectPred("rstmid1", 1'b0, 32'h148); expectFlush("rstmid1", 1'b0, 0); expectStats("rstmid1");
        checkOutput();
        idle(32'h200);
        expectPred("rstmid2", 1'b0, 32'h204);
        checkOutput();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
